// File: rtl/seg7_display_driver.sv
// Dual-digit 7-segment driver: latches a display byte, multiplexes its two hex
// digits with a dark guard window at each digit switch, and dims via 16-step PWM.
module seg7_display_driver #(
    parameter int unsigned REFRESH_DIV    = 12000,
    parameter int unsigned GUARD          = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] value_i,
    input  logic       we_i,
    input  logic [3:0] brightness_i,
    input  logic       blank_i,
    output logic [6:0] seg_o,
    output logic       digit_sel_o
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [7:0]    value_q,      value_d;
    logic [CW-1:0] refreshCnt_q, refreshCnt_d;
    logic [3:0]    pwmCnt_q,     pwmCnt_d;
    logic          digitSel_q,   digitSel_d;
    logic [6:0]    seg_q,        seg_d;
    logic [3:0]    nibble;
    logic          segEnable;

    // Hex digit to active-high {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] encode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Next-state: counters, digit toggle on slot wrap, and the segment pattern,
    // which is gated by the post-edge counter values so seg_o and digit_sel_o agree.
    always_comb begin
        value_d      = we_i ? value_i : value_q;
        pwmCnt_d     = pwmCnt_q + 4'd1;
        refreshCnt_d = refreshCnt_q + {{(CW-1){1'b0}}, 1'b1};
        digitSel_d   = digitSel_q;
        if (refreshCnt_q == CW'(REFRESH_DIV - 1)) begin
            refreshCnt_d = '0;
            digitSel_d   = ~digitSel_q;
        end
        nibble    = digitSel_d ? value_q[7:4] : value_q[3:0];
        segEnable = !blank_i && (refreshCnt_d >= CW'(GUARD)) && (pwmCnt_d <= brightness_i);
        seg_d     = SEG_OFF;
        if (segEnable) begin
            seg_d = SEG_ACTIVE_LOW ? ~encode(nibble) : encode(nibble);
        end
    end

    // State register; reset restarts the low-digit slot and clears the held byte.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            value_q      <= 8'h00;
            refreshCnt_q <= '0;
            pwmCnt_q     <= 4'd0;
            digitSel_q   <= 1'b0;
            seg_q        <= SEG_OFF;
        end else begin
            value_q      <= value_d;
            refreshCnt_q <= refreshCnt_d;
            pwmCnt_q     <= pwmCnt_d;
            digitSel_q   <= digitSel_d;
            seg_q        <= seg_d;
        end
    end

    assign seg_o       = seg_q;
    assign digit_sel_o = digitSel_q;

endmodule
